// File: rtl/core_pkg.sv
// Shared types for the multi-cycle RV32I sequencer: FSM state encoding,
// error codes and the fixed instruction word width.
package core_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_EXEC  = 3'd1,
        ST_MEM   = 3'd2,
        ST_WB    = 3'd3,
        ST_HALT  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_FETCH_TO = 2'd1;
    localparam logic [1:0] ERR_DATA_TO  = 2'd2;
    localparam logic [1:0] ERR_MISALIGN = 2'd3;

endpackage

// File: rtl/hs_timeout_ctr.sv
// Handshake wait counter shared by the FETCH and MEM states. hit flags the
// last allowed wait cycle; TIMEOUT_CYCLES = 0 never hits.
module hs_timeout_ctr #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LIMIT = W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so a disabled timeout cannot wrap into a false hit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != LIMIT)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign hit = (TIMEOUT_CYCLES != 0) && en && (cnt == LIMIT);

endmodule

// File: rtl/mc_core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer with PC, IR and load-data latch.
// Optional perf counters are built only when PERF_CNT_EN is defined.
module mc_core_sequencer
    import core_pkg::*;
#(
    parameter int                XLEN           = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR   = {XLEN{1'b0}},
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter int                CNT_W          = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instruc_mem_valid,
    input  logic [WORD-1:0]   instruction,
    input  logic              data_mem_valid,
    input  logic [XLEN-1:0]   load_data_in,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              rd_write,
    input  logic [XLEN-1:0]   next_pc,
    input  logic              halt_req,
    output logic              instruction_mem_request,
    output logic              instruction_mem_we_re,
    output logic [XLEN-1:0]   pc_address,
    output logic [WORD-1:0]   ir,
    output logic              data_mem_request,
    output logic              data_mem_we_re,
    output logic [XLEN-1:0]   load_data_q,
    output logic              rf_we,
    output logic [2:0]        state_o,
    output logic              halted,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
);

    state_t          state, state_nx;
    logic [1:0]      code_q, code_nx;
    logic [XLEN-1:0] pc_q;
    logic [WORD-1:0] ir_q;
    logic [XLEN-1:0] ld_q;
    logic            st_q;
    logic            wr_q;
    logic            to_hit;

    hs_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_to (
        .clk (clk),
        .rst (rst),
        .clr (state_nx != state),
        .en  ((state == ST_FETCH) || (state == ST_MEM)),
        .hit (to_hit)
    );

    // Handshake: a request is held high for the whole FETCH/MEM state; the
    // memory answers with a single-cycle valid, sampled only in that state.
    // A valid in the same cycle as the timeout hit is accepted.
    always_comb begin
        state_nx = state;
        code_nx  = code_q;
        case (state)
            ST_FETCH: begin
                if (instruc_mem_valid) begin
                    state_nx = ST_EXEC;
                end else if (to_hit) begin
                    state_nx = ST_ERROR;
                    code_nx  = ERR_FETCH_TO;
                end
            end
            ST_EXEC:  state_nx = (is_load || is_store) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (data_mem_valid) begin
                    state_nx = ST_WB;
                end else if (to_hit) begin
                    state_nx = ST_ERROR;
                    code_nx  = ERR_DATA_TO;
                end
            end
            ST_WB: begin
                if (next_pc[1:0] != 2'b00) begin
                    state_nx = ST_ERROR;
                    code_nx  = ERR_MISALIGN;
                end else if (halt_req) begin
                    state_nx = ST_HALT;
                end else begin
                    state_nx = ST_FETCH;
                end
            end
            ST_HALT:  if (!halt_req) state_nx = ST_FETCH;
            ST_ERROR: state_nx = ST_ERROR;
            default:  state_nx = ST_ERROR;
        endcase
    end

    // Decode flags are captured in EXEC so MEM/WB outputs depend on state only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_FETCH;
            code_q <= ERR_NONE;
            pc_q   <= RESET_VECTOR;
            ir_q   <= '0;
            ld_q   <= '0;
            st_q   <= 1'b0;
            wr_q   <= 1'b0;
        end else begin
            state  <= state_nx;
            code_q <= code_nx;
            if ((state == ST_FETCH) && instruc_mem_valid) ir_q <= instruction;
            if (state == ST_EXEC) begin
                st_q <= is_store;
                wr_q <= rd_write & ~is_store;
            end
            if ((state == ST_MEM) && data_mem_valid && !st_q) ld_q <= load_data_in;
            if (state == ST_WB) pc_q <= next_pc;
        end
    end

    assign instruction_mem_request = (state == ST_FETCH) & ~rst;
    assign instruction_mem_we_re   = 1'b0;
    assign data_mem_request        = (state == ST_MEM) & ~rst;
    assign data_mem_we_re          = (state == ST_MEM) & st_q & ~rst;
    assign rf_we                   = (state == ST_WB) & wr_q & ~rst;
    assign pc_address              = pc_q;
    assign ir                      = ir_q;
    assign load_data_q             = ld_q;
    assign state_o                 = state;
    assign halted                  = (state == ST_HALT);
    assign err                     = (state == ST_ERROR);
    assign err_code                = code_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] ret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
            if (state == ST_WB) ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
